uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1-style UART transmitter with a start bit, DATA_BITS data
//               bits sent LSB first, and one stop bit. The line idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 send_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 done_o
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = $clog2(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt,   w_cnt_nxt;
    logic [c_idx_w-1:0]     r_idx,   w_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_tx,    w_tx_nxt;
    logic                   r_done,  w_done_nxt;
    logic                   w_bit_end;

    assign w_bit_end = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt  = 1'b1;
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (send_i) begin
                    w_shift_nxt = data_i;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Shift first so the next bit is always at position 0.
                        w_idx_nxt   = r_idx + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Asynchronous reset drives the line high at once, aborting any frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign tx_o    = r_tx;
    assign done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx; a frame-level model predicts
//               accepted bytes and a line monitor decodes and checks frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepts = 0;
    int free_at = 0;
    int idle_bad = 0;
    int ready_bad = 0;
    bit in_frame = 1'b0;
    logic [7:0] sb[$];
    int start_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data),
        .send_i  (send),
        .ready_o (ready),
        .tx_o    (tx),
        .done_o  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Transaction model: a request is taken whenever the transmitter has been
    // free for a full frame plus the one idle cycle.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) free_at = 0;
        if (ready !== ((cyc + 1 >= free_at) ? 1'b1 : 1'b0)) ready_bad++;
        if (rst_n === 1'b1 && send === 1'b1 && cyc + 1 >= free_at) begin
            sb.push_back(data);
            accepts++;
            free_at = cyc + 1 + FRAME + 1;
        end
    end

    // Line monitor: decodes each frame from tx and compares to the scoreboard.
    initial begin : monitor
        logic [7:0] e;
        logic [7:0] rx;
        logic [9:0] bits;
        logic       last_tx, last_done, have;
        int         bad_bits, bad_done;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) continue;
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                start_q.push_back(cyc);
                have = (sb.size() > 0);
                chk("frame_expected", {31'd0, have}, 32'd1);
                e = have ? sb.pop_front() : 8'h00;
                bits = {1'b1, e, 1'b0};
                rx = 8'h00; bad_bits = 0; bad_done = 0; aborted = 1'b0;
                last_tx = 1'b0; last_done = 1'b0;
                for (int k = 0; k <= FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k < FRAME) begin
                        if (tx !== bits[k / CPB]) bad_bits++;
                        if (done !== 1'b0) bad_done++;
                        if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= DB)
                            rx[k / CPB - 1] = tx;
                    end else begin
                        last_tx = tx;
                        last_done = done;
                    end
                end
                if (!aborted) begin
                    chk("frame_data", {24'd0, rx}, {24'd0, e});
                    chk("frame_bits", bad_bits, 0);
                    chk("done_in_frame", bad_done, 0);
                    chk("done_pulse", {31'd0, last_done}, 32'd1);
                    chk("tx_after_stop", {31'd0, last_tx}, 32'd1);
                end
                in_frame = 1'b0;
            end else if (done !== 1'b0) begin
                idle_bad++;
            end
        end
    end

    task automatic issue(input logic [7:0] d);
        int a0;
        a0 = accepts;
        send = 1'b1;
        data = d;
        for (int i = 0; i < 200 && accepts == a0; i++) begin
            @(posedge clk);
            #1;
        end
        send = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !in_frame && ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_idle");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ib;
        int n;
        int a0;
        bit ok;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        ib = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) ib++;
        end
        chk("idle_100", ib, 0);
        @(posedge clk);
        #1;

        issue(8'h55);
        wait_idle();

        issue(8'hA3);
        data = 8'hFF;
        wait_idle();

        // Back-to-back with send held high.
        n = start_q.size();
        a0 = accepts;
        send = 1'b1;
        data = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (accepts == a0 + 1) data = 8'hFF;
            if (accepts == a0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        send = 1'b0;
        if (!ok) timeout_fail("b2b_accepts");
        wait_idle();
        if (start_q.size() >= n + 2) chk("b2b_period", start_q[n + 1] - start_q[n], FRAME + 1);
        else timeout_fail("b2b_frames");

        // Requests during DATA are ignored.
        issue(8'h96);
        repeat (12) @(posedge clk);
        #1;
        send = 1'b1; data = 8'h0F;
        @(posedge clk);
        #1;
        send = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send = 1'b1; data = 8'hF0;
        @(posedge clk);
        #1;
        send = 1'b0;
        wait_idle();

        // Reset mid-frame.
        issue(8'h3C);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_ready", {31'd0, ready}, 32'd1);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        issue(8'hC5);
        chk("accept_after_reset", {31'd0, ready}, 32'd0);
        wait_idle();

        // Randomized traffic with stray requests during frames.
        for (int f = 0; f < 20; f++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(d);
            repeat ($urandom_range(5, 45)) begin
                send = 1'($urandom_range(0, 1));
                data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            send = 1'b0;
        end
        wait_idle();

        chk("idle_done_glitch", idle_bad, 0);
        chk("ready_model", ready_bad, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
